// File: rtl/dmem_copy.sv
// dmem_copy: byte block-copy engine driving the data memory port (combinational read, clocked write).
// Optional fill mode is compiled in when DMEM_COPY_FILL_EN is defined.
module dmem_copy #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic          wm,
  output logic [AW-1:0] ad,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
`ifdef DMEM_COPY_FILL_EN
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
`endif
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_sp;
  logic [AW-1:0] r_dp;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_buf;
  logic [DW-1:0] r_sum;
  logic          w_last;
`ifdef DMEM_COPY_FILL_EN
  logic          r_fill;
`endif

  assign w_last = (r_cnt == AW'(1));

  // Handshake: start is a request honoured only in IDLE (no queueing); busy spans RD/WR,
  // done is a single-cycle pulse, and sum holds from DONE until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sp    <= '0;
      r_dp    <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_sum   <= '0;
`ifdef DMEM_COPY_FILL_EN
      r_fill  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sp  <= src;
            r_dp  <= dst;
            r_cnt <= len;
            r_sum <= '0;
`ifdef DMEM_COPY_FILL_EN
            r_fill <= fill;
            r_buf  <= fill_val;
            if (len == '0)   r_state <= S_DONE;
            else if (fill)   r_state <= S_WR;
            else             r_state <= S_RD;
`else
            r_state <= (len == '0) ? S_DONE : S_RD;
`endif
          end
        end
        S_RD: begin
          r_buf   <= din;
          r_sp    <= r_sp + 1'b1;
          r_state <= S_WR;
        end
        S_WR: begin
          r_sum <= r_sum ^ r_buf;
          r_dp  <= r_dp + 1'b1;
          r_cnt <= r_cnt - 1'b1;
`ifdef DMEM_COPY_FILL_EN
          if (w_last)      r_state <= S_DONE;
          else if (r_fill) r_state <= S_WR;
          else             r_state <= S_RD;
`else
          r_state <= w_last ? S_DONE : S_RD;
`endif
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode only registered state, so input changes never glitch them.
  assign busy      = (r_state == S_RD) || (r_state == S_WR);
  assign done      = (r_state == S_DONE);
  assign wm        = (r_state == S_WR);
  assign ad        = (r_state == S_RD) ? r_sp : ((r_state == S_WR) ? r_dp : '0);
  assign dout      = (r_state == S_WR) ? r_buf : '0;
  assign sum       = r_sum;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_copy.sv
// tb_dmem_copy: bench for dmem_copy with a behavioural dmem, a byte-level reference model
// and a per-cycle compare process fed by an expected queue.
module tb_dmem_copy;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       wm;
  logic [7:0] ad;
  logic [7:0] dout;
  logic [7:0] din;
  logic [1:0] dbg_state;
`ifdef DMEM_COPY_FILL_EN
  logic       fill;
  logic [7:0] fill_val;
`endif

  // dmem model and poke port used to preload it while the engine is idle
  logic [7:0] mem [256];
  logic       pk_en;
  logic [7:0] pk_a;
  logic [7:0] pk_d;

  // reference model state
  logic [7:0]  ref_mem [256];
  logic [26:0] exp_q[$];   // {busy, done, wm, ad, dout, sum}
  logic [7:0]  sum_hold;
  logic        model_idle;
  logic        after_rst;
  int          busy_cnt;
  int          wm_cnt;
  int          done_cnt;

  int n_checks;
  int n_fail;

  dmem_copy #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .wm       (wm),
    .ad       (ad),
    .dout     (dout),
    .din      (din),
`ifdef DMEM_COPY_FILL_EN
    .fill     (fill),
    .fill_val (fill_val),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign din = mem[ad];

  always @(posedge clk) begin
    if (wm)         mem[ad]   <= dout;
    else if (pk_en) mem[pk_a] <= pk_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is expanded at acceptance into the per-cycle output
  // stream it must produce, walking the bytes in ascending order on a private memory copy.
  initial begin : model
    logic [26:0] e;
    logic [7:0]  s_a;
    logic [7:0]  d_a;
    logic [7:0]  acc;
    logic [7:0]  b;
    logic [7:0]  cpy [256];
    int          n;
    sum_hold   = 8'h00;
    model_idle = 1'b1;
    after_rst  = 1'b1;
    busy_cnt   = 0;
    wm_cnt     = 0;
    done_cnt   = 0;
    forever begin
      @(posedge clk);
      if (pk_en && !wm) ref_mem[pk_a] = pk_d;
      if (rst) begin
        exp_q.delete();
        sum_hold  = 8'h00;
        after_rst = 1'b1;
      end else if (start && model_idle) begin
        s_a = src;
        d_a = dst;
        acc = 8'h00;
        n   = int'(len);
        cpy = ref_mem;
        for (int k = 0; k < n; k++) begin
`ifdef DMEM_COPY_FILL_EN
          if (fill) b = fill_val;
          else begin
            b = cpy[s_a];
            exp_q.push_back({1'b1, 1'b0, 1'b0, s_a, 8'h00, 8'h00});
          end
`else
          b = cpy[s_a];
          exp_q.push_back({1'b1, 1'b0, 1'b0, s_a, 8'h00, 8'h00});
`endif
          exp_q.push_back({1'b1, 1'b0, 1'b1, d_a, b, 8'h00});
          cpy[d_a] = b;
          acc = acc ^ b;
          s_a = s_a + 8'd1;
          d_a = d_a + 8'd1;
        end
        exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h00, 8'h00, acc});
        after_rst  = 1'b0;
        model_idle = 1'b0;
      end

      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        model_idle = 1'b0;
        chk("busy", 32'(busy), 32'(e[26]));
        chk("done", 32'(done), 32'(e[25]));
        chk("wm",   32'(wm),   32'(e[24]));
        if (e[26]) chk("ad", 32'(ad), 32'(e[23:16]));
        if (e[24]) begin
          chk("dout", 32'(dout), 32'(e[15:8]));
          ref_mem[e[23:16]] = e[15:8];
        end
        if (e[25]) begin
          chk("sum_at_done", 32'(sum), 32'(e[7:0]));
          sum_hold = e[7:0];
        end
      end else begin
        model_idle = 1'b1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wm",   32'(wm),   32'd0);
        chk("idle_sum",  32'(sum),  32'(sum_hold));
        if (after_rst) begin
          chk("rst_ad",   32'(ad),   32'd0);
          chk("rst_dout", 32'(dout), 32'd0);
        end
      end
      if (busy) busy_cnt++;
      if (wm)   wm_cnt++;
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pk_en = 1'b1;
    pk_a  = a;
    pk_d  = d;
    tick();
    pk_en = 1'b0;
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int target);
    int i;
    i = 0;
    while ((done_cnt - base) < target && i < 700) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("done_within_bound", 32'((done_cnt - base) >= target), 32'd1);
    tick();
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          output int nb, output int nw, output int nd);
    int b0, w0, d0;
    b0 = busy_cnt;
    w0 = wm_cnt;
    d0 = done_cnt;
    launch(s, d, l);
    wait_done(d0, 1);
    nb = busy_cnt - b0;
    nw = wm_cnt - w0;
    nd = done_cnt - d0;
  endtask

  task automatic check_image(input string nm);
    int mis;
    mis = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) mis++;
    chk(nm, 32'(mis), 32'd0);
  endtask

  initial begin : stim
    int nb, nw, nd, b0, w0, d0;
    logic [7:0] rs, rd, rl;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b0;
    src   = 8'h00;
    dst   = 8'h00;
    len   = 8'h00;
    pk_en = 1'b0;
    pk_a  = 8'h00;
    pk_d  = 8'h00;
`ifdef DMEM_COPY_FILL_EN
    fill     = 1'b0;
    fill_val = 8'h00;
`endif

    // reset then idle
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",  32'(busy),      32'd0);
    chk("reset_done",  32'(done),      32'd0);
    chk("reset_wm",    32'(wm),        32'd0);
    chk("reset_ad",    32'(ad),        32'd0);
    chk("reset_dout",  32'(dout),      32'd0);
    chk("reset_sum",   32'(sum),       32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    w0 = wm_cnt;
    repeat (10) tick();
    chk("idle_no_wm", 32'(wm_cnt - w0), 32'd0);

    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));

    // basic copy
    poke(8'h10, 8'hA1);
    poke(8'h11, 8'hB2);
    poke(8'h12, 8'hC3);
    poke(8'h13, 8'hD4);
    run_copy(8'h10, 8'h40, 8'd4, nb, nw, nd);
    chk("basic_busy_cycles", 32'(nb), 32'd8);
    chk("basic_done_pulses", 32'(nd), 32'd1);
    chk("basic_b0", 32'(mem[8'h40]), 32'hA1);
    chk("basic_b1", 32'(mem[8'h41]), 32'hB2);
    chk("basic_b2", 32'(mem[8'h42]), 32'hC3);
    chk("basic_b3", 32'(mem[8'h43]), 32'hD4);
    chk("basic_sum", 32'(sum), 32'h04);

    // address wrap
    poke(8'hFE, 8'h11);
    poke(8'hFF, 8'h22);
    poke(8'h00, 8'h33);
    run_copy(8'hFE, 8'h80, 8'd3, nb, nw, nd);
    chk("wrap_b0", 32'(mem[8'h80]), 32'h11);
    chk("wrap_b1", 32'(mem[8'h81]), 32'h22);
    chk("wrap_b2", 32'(mem[8'h82]), 32'h33);
    chk("wrap_sum", 32'(sum), 32'h00);

    // zero length
    run_copy(8'h05, 8'h06, 8'd0, nb, nw, nd);
    chk("len0_busy", 32'(nb), 32'd0);
    chk("len0_wm",   32'(nw), 32'd0);
    chk("len0_done", 32'(nd), 32'd1);
    chk("len0_sum",  32'(sum), 32'd0);

    // start pulsed while busy is ignored
    b0 = busy_cnt;
    w0 = wm_cnt;
    d0 = done_cnt;
    launch(8'h50, 8'h60, 8'd2);
    tick();
    src   = 8'h70;
    dst   = 8'h71;
    len   = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 1);
    repeat (3) tick();
    chk("ignored_start_wm",   32'(wm_cnt - w0),   32'd2);
    chk("ignored_start_done", 32'(done_cnt - d0), 32'd1);
    chk("ignored_start_busy", 32'(busy_cnt - b0), 32'd4);

    // overlapping dst = src + 1 propagates the first byte
    poke(8'h90, 8'h7E);
    run_copy(8'h90, 8'h91, 8'd5, nb, nw, nd);
    for (int a = 8'h91; a <= 8'h95; a++) chk("overlap_byte", 32'(mem[a]), 32'h7E);
    chk("overlap_sum", 32'(sum), 32'h7E);

    // start held through DONE relaunches once in the following IDLE cycle
    b0 = busy_cnt;
    w0 = wm_cnt;
    d0 = done_cnt;
    src   = 8'h10;
    dst   = 8'hA0;
    len   = 8'd1;
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    wait_done(d0, 2);
    repeat (3) tick();
    chk("held_start_done", 32'(done_cnt - d0), 32'd2);
    chk("held_start_wm",   32'(wm_cnt - w0),   32'd2);
    chk("held_start_busy", 32'(busy_cnt - b0), 32'd4);

    // reset in the third busy cycle of a 4-byte copy
    poke(8'hB1, 8'hEE);
    w0 = wm_cnt;
    d0 = done_cnt;
    launch(8'h10, 8'hB0, 8'd4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("rst_mid_writes", 32'(wm_cnt - w0),   32'd1);
    chk("rst_mid_done",   32'(done_cnt - d0), 32'd0);
    chk("rst_mid_b0",     32'(mem[8'hB0]),    32'hA1);
    chk("rst_mid_b1",     32'(mem[8'hB1]),    32'hEE);
    chk("rst_mid_sum",    32'(sum),           32'd0);
    check_image("image_directed");

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      rs = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0:       rl = 8'd0;
        1:       rl = 8'($urandom_range(100, 255));
        default: rl = 8'($urandom_range(1, 24));
      endcase
      run_copy(rs, rd, rl, nb, nw, nd);
      chk("rand_busy_cycles", 32'(nb), 32'(2 * int'(rl)));
      chk("rand_writes",      32'(nw), 32'(rl));
      repeat ($urandom_range(0, 3)) tick();
    end
    check_image("image_random");

`ifdef DMEM_COPY_FILL_EN
    fill     = 1'b1;
    fill_val = 8'h5A;
    run_copy(8'h00, 8'h20, 8'd3, nb, nw, nd);
    fill     = 1'b0;
    chk("fill_busy", 32'(nb), 32'd3);
    chk("fill_b0", 32'(mem[8'h20]), 32'h5A);
    chk("fill_b1", 32'(mem[8'h21]), 32'h5A);
    chk("fill_b2", 32'(mem[8'h22]), 32'h5A);
    chk("fill_sum", 32'(sum), 32'h5A);
    check_image("image_fill");
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_copy.md
# dmem_copy

Block-transfer engine sitting directly upstream of the data memory `dmem`. It drives dmem's write-enable, address and write-data ports and consumes its read data, copying `len` consecutive bytes from a source region to a destination region. A start/busy/done handshake lets the control path launch a transfer and wait for completion. A running XOR checksum of the transferred bytes is available at the end.

## Interface
- `AW`, 8, address width (matches dmem `ad`)
- `DW`, 8, data width (matches dmem `in`/`out`)

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch request; sampled only in IDLE
- `src`  in  AW  first source address; captured on accepted start
- `dst`  in  AW  first destination address; captured on accepted start
- `len`  in  AW  byte count, 0..255; captured on accepted start
- `busy`  out  1  high while in RD or WR
- `done`  out  1  one-cycle pulse in DONE state
- `sum`  out  DW  XOR of all bytes written by the last transfer
- `wm`  out  1  to dmem `wm`; high only in WR
- `ad`  out  AW  to dmem `ad`
- `dout`  out  DW  to dmem `in`
- `din`  in  DW  from dmem `out`
- `fill`  in  1  fill mode select (only with `DMEM_COPY_FILL_EN`)
- `fill_val`  in  DW  fill byte (only with `DMEM_COPY_FILL_EN`)

## Operation
- dmem contract: read is combinational (`din` reflects `ad` in the same cycle); write commits at rising `clk` when `wm`=1.
- States: IDLE, RD, WR, DONE.
- IDLE: `start`=1 -> capture `src`,`dst`,`len` into `sp`,`dp`,`cnt`; clear `sum`. If `len`=0 -> DONE, else -> RD.
- RD: `ad`=`sp`, `wm`=0; at edge latch `din` into `buf`; `sp`<=`sp`+1; -> WR.
- WR: `ad`=`dp`, `dout`=`buf`, `wm`=1; at edge `sum`<=`sum`^`buf`, `dp`<=`dp`+1, `cnt`<=`cnt`-1; `cnt`=1 -> DONE, else -> RD.
- DONE: `done`=1, `busy`=0; -> IDLE unconditionally.
- Address arithmetic modulo 2^AW: 0xFF+1 wraps to 0x00, no error.
- Overlapping regions: strictly ascending byte order, one read then one write per byte; `dst`=`src`+1 therefore propagates the first byte (defined, not an error).
- `start` outside IDLE ignored; no queueing. `start` held high through DONE relaunches in the IDLE cycle after DONE.
- `src`/`dst`/`len` changes after acceptance have no effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `wm` 0, `ad` 0, `dout` 0, `sum` 0, internal registers 0.
- `rst` mid-transfer: at next edge return to IDLE; `wm` low from that edge; no further writes; `done` not pulsed; bytes already written stay written.
- `wm`, `ad`, `dout`, `busy`, `done` are decoded from registered state and pointers (glitch-free w.r.t. inputs).
- Start accepted at edge E0; RD occupies cycle after E0; transfer of N>0 bytes: `busy` high exactly 2N cycles, `done` in cycle 2N+1 after E0.
- `len`=0: `done` in cycle immediately after E0, `busy` never high, no `wm` pulse.
- `sum` stable and valid from the DONE cycle until next accepted start.

## Configuration
- Macro `DMEM_COPY_FILL_EN`.
- Defined: `fill` and `fill_val` ports exist; `fill` captured at start; when set, RD state skipped (IDLE/WR -> WR directly), `dout`=`fill_val`, `busy` high N cycles, `done` at cycle N+1; `sum` = XOR of `fill_val` N times.
- Undefined: ports absent, copy-only behaviour above; RTL must not reference `fill`/`fill_val`.

## Test plan
- Reset then idle: `rst` 2 cycles -> all outputs 0, `wm` never high for 10 cycles with `start`=0.
- Basic copy: dmem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; start src=0x10 dst=0x40 len=4 -> `busy` 8 cycles, `done` 1 cycle, dmem[0x40..0x43] match, `sum`=0x00^A1^B2^C3^D4=0x04.
- Wrap: dmem[0xFE]=0x11, dmem[0xFF]=0x22, dmem[0x00]=0x33; src=0xFE dst=0x80 len=3 -> dmem[0x80..0x82]=0x11,0x22,0x33.
- Zero length and ignored start: len=0 -> `done` next cycle, no `wm`; pulse `start` during `busy` of a len=2 copy -> exactly 2 writes, one `done`.
- Reset mid-op: len=4 copy, `rst` asserted in third busy cycle -> exactly one destination byte written, no `done`, outputs at reset values next cycle.
- Fill (with `DMEM_COPY_FILL_EN`): fill=1 fill_val=0x5A dst=0x20 len=3 -> dmem[0x20..0x22]=0x5A, `busy` 3 cycles, `sum`=0x5A.
